// File: rtl/spi_byte_sequencer.sv
// SPI byte sequencer: TX/RX byte FIFOs plus chip-select framing around the
// SPI host's start / next-byte handshake, keeping CS low across back-to-back bytes.
module spi_byte_sequencer #(
    parameter int TxDepth       = 4,
    parameter int RxDepth       = 4,
    parameter int CsSetupCycles = 2,
    parameter int CsHoldCycles  = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       rx_valid_o,
    output logic [7:0] rx_data_o,
    input  logic       rx_ready_i,
    input  logic       clear_i,
    output logic       rx_overflow_o,
    output logic       busy_o,
    output logic       cs_n_o,
    output logic       host_start_o,
    output logic [7:0] host_byte_o,
    input  logic       host_done_i,
    input  logic [7:0] host_byte_i
);

    localparam int CntMax = (CsSetupCycles > CsHoldCycles) ? CsSetupCycles : CsHoldCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam int TxAw   = $clog2(TxDepth);
    localparam int RxAw   = $clog2(RxDepth);

    localparam logic [CntW-1:0] SetupLast = CntW'(CsSetupCycles - 1);
    localparam logic [CntW-1:0] HoldLast  = CntW'(CsHoldCycles - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_HOLD
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            done_q;
    logic            done_rise;
    logic            tx_pop;
    logic            rx_capture;

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem [TxDepth];
    logic [TxAw-1:0] tx_wptr, tx_rptr;
    logic [TxAw:0]   tx_count;
    logic            tx_push, tx_empty, tx_full;
    logic [7:0]      tx_head;

    assign tx_full    = (tx_count == (TxAw + 1)'(TxDepth));
    assign tx_empty   = (tx_count == '0);
    assign tx_ready_o = !tx_full;
    assign tx_push    = tx_valid_i && !tx_full;
    assign tx_head    = tx_mem[tx_rptr];

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_count <= '0;
        end else begin
            if (tx_push) tx_wptr <= tx_wptr + TxAw'(1);
            if (tx_pop)  tx_rptr <= tx_rptr + TxAw'(1);
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + (TxAw + 1)'(1);
                2'b01:   tx_count <= tx_count - (TxAw + 1)'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage arrays are not reset; the pointers and counts alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr] <= tx_data_i;
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]      rx_mem [RxDepth];
    logic [RxAw-1:0] rx_wptr, rx_rptr;
    logic [RxAw:0]   rx_count;
    logic            rx_push, rx_pop, rx_full;
    logic            overflow_q;

    assign rx_full       = (rx_count == (RxAw + 1)'(RxDepth));
    assign rx_valid_o    = (rx_count != '0);
    assign rx_data_o     = rx_valid_o ? rx_mem[rx_rptr] : 8'h00;
    assign rx_pop        = rx_valid_o && rx_ready_i;
    assign rx_push       = rx_capture && !rx_full;
    assign rx_overflow_o = overflow_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            rx_count   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (rx_push) rx_wptr <= rx_wptr + RxAw'(1);
            if (rx_pop)  rx_rptr <= rx_rptr + RxAw'(1);
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (RxAw + 1)'(1);
                2'b01:   rx_count <= rx_count - (RxAw + 1)'(1);
                default: ;
            endcase
            // A drop outranks a simultaneous clear so no lost byte goes unreported.
            if (rx_capture && rx_full) overflow_q <= 1'b1;
            else if (clear_i)          overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rx_push) rx_mem[rx_wptr] <= host_byte_i;
    end

    // ---------------- Sequencer FSM ----------------
    assign done_rise = host_done_i && !done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CntW'(1);
            done_q  <= host_done_i;
        end
    end

    always_comb begin
        // NOTE: every signal driven here gets a default first so no path infers a latch.
        state_d    = state_q;
        tx_pop     = 1'b0;
        rx_capture = 1'b0;
        case (state_q)
            ST_IDLE:  if (!tx_empty) state_d = ST_SETUP;
            ST_SETUP: if (cnt_q == SetupLast) state_d = ST_ISSUE;
            ST_ISSUE: begin
                tx_pop  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    rx_capture = 1'b1;
                    state_d    = ST_GAP;
                end
            end
            // Host must be back at idle (done low) before it may see another start.
            ST_GAP:   if (!host_done_i) state_d = tx_empty ? ST_HOLD : ST_ISSUE;
            ST_HOLD: begin
                if (tx_push || !tx_empty)  state_d = ST_ISSUE;
                else if (cnt_q == HoldLast) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // The byte register loads on the ISSUE pop; during ISSUE itself the head is
    // forwarded so host_start_o and host_byte_o become valid in the same cycle.
    logic [7:0] host_byte_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)       host_byte_q <= 8'h00;
        else if (tx_pop) host_byte_q <= tx_head;
    end

    assign host_byte_o  = (state_q == ST_ISSUE) ? tx_head : host_byte_q;
    assign host_start_o = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
    assign cs_n_o       = (state_q == ST_IDLE);
    assign busy_o       = (state_q != ST_IDLE);

endmodule
